// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
package fp_pkg;

    // Operand / special-case class carried down the pipeline.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the 4-bit exception flag vector.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             in_bits,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Scan from LSB upwards so the highest set bit wins the final assignment.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_bits[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready
// handshakes, round-to-nearest-even, flush-to-zero and exception flags.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_op,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [3:0]             out_flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 4;                 // {hidden, man, guard, round, sticky}
    localparam int LZW  = $clog2(SW + 1);
    localparam int EW   = EXP_W + LZW + 2;           // working exponent, two's complement
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) begin
            return ZERO;                             // zero and subnormal (flushed)
        end else if (&e) begin
            return (m == '0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

    // ---------------- pipeline state ----------------
    logic              s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    fp_class_e         s1_cls_q,   s1_cls_d;
    logic [W-1:0]      s1_byp_q,   s1_byp_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic [SW-1:0]     s1_mx_q,    s1_mx_d;
    logic [SW-1:0]     s1_my_q,    s1_my_d;
    logic              s1_sub_q,   s1_sub_d;

    logic              s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    fp_class_e         s2_cls_q,   s2_cls_d;
    logic [W-1:0]      s2_byp_q,   s2_byp_d;
    logic              s2_sign_q,  s2_sign_d;
    logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
    logic [SW:0]       s2_sum_q,   s2_sum_d;

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q,  out_data_d;
    logic [3:0]        out_flags_q, out_flags_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

    // Whole pipeline moves in lock-step whenever the output slot can take a result.
    logic adv;
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = rst_n && adv;

    // ---------------- S1: unpack / classify / swap / align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    fp_class_e        cls_a, cls_b;

    assign sa    = in_a[W-1];
    assign ea    = in_a[W-2:MAN_W];
    assign ma    = in_a[MAN_W-1:0];
    assign sb    = in_b[W-1] ^ in_op;                // subtraction flips B's sign here
    assign eb    = in_b[W-2:MAN_W];
    assign mb    = in_b[MAN_W-1:0];
    assign cls_a = classify(ea, ma);
    assign cls_b = classify(eb, mb);

    logic             a_ge, sx, sy;
    logic [EXP_W-1:0] ex, ey, dexp;
    logic [MAN_W-1:0] fx, fy;
    logic [SW-1:0]    y_ext, y_mask, y_al;
    fp_class_e        sp_cls;
    logic [W-1:0]     sp_byp;

    // Order operands by magnitude, align the smaller one and resolve special cases.
    always_comb begin
        a_ge   = (ea > eb) || ((ea == eb) && (ma >= mb));
        sx     = a_ge ? sa : sb;
        ex     = a_ge ? ea : eb;
        fx     = a_ge ? ma : mb;
        sy     = a_ge ? sb : sa;
        ey     = a_ge ? eb : ea;
        fy     = a_ge ? mb : ma;
        dexp   = ex - ey;
        y_ext  = {1'b1, fy, 3'b000};
        // Bits shifted past the LSB collapse into the sticky position.
        y_mask = ~({SW{1'b1}} << dexp);
        y_al   = (y_ext >> dexp) | {{(SW-1){1'b0}}, |(y_ext & y_mask)};

        sp_cls = NORM;
        sp_byp = '0;
        if ((cls_a == NAN) || (cls_b == NAN) || ((cls_a == INF) && (cls_b == INF) && (sa != sb))) begin
            sp_cls = NAN;
        end else if (cls_a == INF) begin
            sp_cls = INF;
            sp_byp = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_b == INF) begin
            sp_cls = INF;
            sp_byp = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((cls_a == ZERO) && (cls_b == ZERO)) begin
            sp_cls = ZERO;
            sp_byp = {sa & sb, {(W-1){1'b0}}};       // only -0 + -0 keeps the sign
        end else if (cls_a == ZERO) begin
            sp_cls = ZERO;
            sp_byp = {sb, eb, mb};
        end else if (cls_b == ZERO) begin
            sp_cls = ZERO;
            sp_byp = {sa, ea, ma};
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [LZW-1:0]  lz;
    logic [SW-1:0]   n;
    logic [EW-1:0]   e_n, e_r;
    logic [MAN_W:0]  frac_r;
    logic            rup, grs_any, ovf, unf;
    logic [W-1:0]    res_data;
    logic [3:0]      res_flags;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .in_bits (s2_sum_q[SW-1:0]),
        .count   (lz)
    );

    // Normalise the raw sum, round to nearest-even and saturate the exponent.
    always_comb begin
        if (s2_sum_q[SW]) begin
            n   = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
            e_n = EW'(s2_exp_q) + EW'(1);
        end else begin
            n   = s2_sum_q[SW-1:0] << lz;
            e_n = EW'(s2_exp_q) - EW'(lz);
        end
        grs_any = |n[2:0];
        rup     = n[2] & (n[1] | n[0] | n[3]);
        frac_r  = {1'b0, n[SW-2:3]} + (MAN_W+1)'(rup);
        e_r     = e_n + EW'(frac_r[MAN_W]);         // rounding carried into the exponent
        ovf     = !e_r[EW-1] && (e_r >= EW'(EMAX));
        unf     = e_r[EW-1] || (e_r == '0);

        res_data  = '0;
        res_flags = '0;
        case (s2_cls_q)
            NAN: begin
                res_data                = QNAN;
                res_flags[FLAG_INVALID] = 1'b1;
            end
            INF, ZERO: begin
                res_data = s2_byp_q;
            end
            default: begin
                if (!n[SW-1]) begin
                    res_data = '0;                   // exact cancellation gives +0
                end else if (ovf) begin
                    res_data                 = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    res_flags[FLAG_OVERFLOW] = 1'b1;
                    res_flags[FLAG_INEXACT]  = 1'b1;
                end else if (unf) begin
                    res_data                  = {s2_sign_q, {(W-1){1'b0}}};
                    res_flags[FLAG_UNDERFLOW] = 1'b1;
                    res_flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    res_data                = {s2_sign_q, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    res_flags[FLAG_INEXACT] = grs_any;
                end
            end
        endcase
    end

    // Next-state for every stage; data only loads behind a valid slot so held outputs stay put.
    always_comb begin
        s1_valid_d = s1_valid_q;  s1_tag_d = s1_tag_q;   s1_cls_d = s1_cls_q;
        s1_byp_d   = s1_byp_q;    s1_sign_d = s1_sign_q; s1_exp_d = s1_exp_q;
        s1_mx_d    = s1_mx_q;     s1_my_d = s1_my_q;     s1_sub_d = s1_sub_q;
        s2_valid_d = s2_valid_q;  s2_tag_d = s2_tag_q;   s2_cls_d = s2_cls_q;
        s2_byp_d   = s2_byp_q;    s2_sign_d = s2_sign_q; s2_exp_d = s2_exp_q;
        s2_sum_d   = s2_sum_q;
        out_valid_d = out_valid_q; out_data_d = out_data_q;
        out_flags_d = out_flags_q; out_tag_d  = out_tag_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (in_valid) begin
                s1_tag_d  = in_tag;
                s1_cls_d  = sp_cls;
                s1_byp_d  = sp_byp;
                s1_sign_d = sx;
                s1_exp_d  = ex;
                s1_mx_d   = {1'b1, fx, 3'b000};
                s1_my_d   = y_al;
                s1_sub_d  = sx ^ sy;
            end
            if (s1_valid_q) begin
                s2_tag_d  = s1_tag_q;
                s2_cls_d  = s1_cls_q;
                s2_byp_d  = s1_byp_q;
                s2_sign_d = s1_sign_q;
                s2_exp_d  = s1_exp_q;
                // |X| >= |Y| so the difference never goes negative.
                s2_sum_d  = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                                     : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});
            end
            if (s2_valid_q) begin
                out_data_d  = res_data;
                out_flags_d = res_flags;
                out_tag_d   = s2_tag_q;
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;  s1_tag_q <= '0;  s1_cls_q <= ZERO;  s1_byp_q <= '0;
            s1_sign_q  <= 1'b0;  s1_exp_q <= '0;  s1_mx_q  <= '0;    s1_my_q  <= '0;
            s1_sub_q   <= 1'b0;
            s2_valid_q <= 1'b0;  s2_tag_q <= '0;  s2_cls_q <= ZERO;  s2_byp_q <= '0;
            s2_sign_q  <= 1'b0;  s2_exp_q <= '0;  s2_sum_q <= '0;
            out_valid_q <= 1'b0; out_data_q <= '0; out_flags_q <= '0; out_tag_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;  s1_tag_q <= s1_tag_d;  s1_cls_q <= s1_cls_d;
            s1_byp_q   <= s1_byp_d;    s1_sign_q <= s1_sign_d; s1_exp_q <= s1_exp_d;
            s1_mx_q    <= s1_mx_d;     s1_my_q <= s1_my_d;    s1_sub_q <= s1_sub_d;
            s2_valid_q <= s2_valid_d;  s2_tag_q <= s2_tag_d;  s2_cls_q <= s2_cls_d;
            s2_byp_q   <= s2_byp_d;    s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d;
            s2_sum_q   <= s2_sum_d;
            out_valid_q <= out_valid_d; out_data_q <= out_data_d;
            out_flags_q <= out_flags_d; out_tag_q  <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: binary32 instance plus a half-precision instance.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_op, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_a, in_b, out_data;
    logic [3:0]  in_tag, out_tag, out_flags;

    logic        h_in_valid, h_in_op, h_out_ready;
    logic        h_in_ready, h_out_valid;
    logic [15:0] h_in_a, h_in_b, h_out_data;
    logic [3:0]  h_in_tag, h_out_tag, h_out_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .out_tag(out_tag)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_op(h_in_op), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_data(h_out_data), .out_flags(h_out_flags), .out_tag(h_out_tag)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    // Drive one operation (out_ready high) and collect its result and latency; no checking here.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [3:0] tag, output logic [31:0] d, output logic [3:0] f,
                          output logic [3:0] t, output int lat);
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data; f = out_flags; t = out_tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_in_a = '0; h_in_b = '0; h_in_op = 1'b0; h_in_tag = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        total++; if (out_flags !== 4'h0 || out_tag !== 4'h0) begin bad++; $display("FAIL reset_flags_tag got %h/%h want 0/0", out_flags, out_tag); end
        total++; if (h_out_valid !== 1'b0) begin bad++; $display("FAIL reset_h_out_valid got %b want 0", h_out_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        $display("reset: checked idle state and release");
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [3:0] f, t; int lat;
        @(posedge clk); #1;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 4'hA, d, f, t, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got %0d want 3", lat); end
        total++; if (d !== 32'h40000000) begin bad++; $display("FAIL basic_data got %h want 40000000", d); end
        total++; if (f !== 4'h0) begin bad++; $display("FAIL basic_flags got %h want 0", f); end
        total++; if (t !== 4'hA) begin bad++; $display("FAIL basic_tag got %h want a", t); end
        $display("basic: 3F800000+3F800000 -> %h flags %h lat %0d", d, f, lat);
    endtask

    task automatic test_arith();
        vec_t v[17];
        logic [31:0] d; logic [3:0] f, t; int lat;
        v[0]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'h0};
        v[1]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        v[2]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
        v[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
        v[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        v[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        v[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        v[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
        v[8]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
        v[9]  = '{32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 4'h0};
        v[10] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0};
        v[11] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3};
        v[12] = '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'h0};
        v[13] = '{32'h3F800000, 32'h3E800000, 1'b1, 32'h3F400000, 4'h0};
        v[14] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'h0};
        v[15] = '{32'h3F000000, 32'h3F800000, 1'b1, 32'hBF000000, 4'h0};
        v[16] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        for (int i = 0; i < 17; i++) begin
            run_op(v[i].a, v[i].b, v[i].op, 4'(i), d, f, t, lat);
            total++; if (d !== v[i].res) begin bad++; $display("FAIL arith%0d_data got %h want %h", i, d, v[i].res); end
            total++; if (f !== v[i].fl) begin bad++; $display("FAIL arith%0d_flags got %h want %h", i, f, v[i].fl); end
            total++; if (t !== 4'(i) || lat != 3) begin bad++; $display("FAIL arith%0d_tag_lat got %h/%0d want %h/3", i, t, lat, 4'(i)); end
            $display("arith%0d: %h %s %h -> %h flags %h", i, v[i].a, v[i].op ? "-" : "+", v[i].b, d, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sa[8];
        logic [31:0] se[8];
        logic [31:0] held_d;
        logic [3:0]  held_t;
        logic        held;
        int sent, rcv, cyc, stalls, extra;
        sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        se = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        sent = 0; rcv = 0; cyc = 0; stalls = 0; held = 1'b0; held_d = '0; held_t = '0;
        @(posedge clk); #1;
        in_op = 1'b0; in_b = 32'h3F800000; out_ready = 1'b1;
        in_valid = 1'b1; in_a = sa[0]; in_tag = 4'd0;
        while (rcv < 8 && cyc < 200) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stalls++;
                if (held) begin
                    total++;
                    if (out_data !== held_d || out_tag !== held_t) begin
                        bad++; $display("FAIL stall_stable got %h/%h want %h/%h", out_data, out_tag, held_d, held_t);
                    end
                end
                held = 1'b1; held_d = out_data; held_t = out_tag;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                total++; if (out_tag !== 4'(rcv)) begin bad++; $display("FAIL stream_tag got %h want %h", out_tag, 4'(rcv)); end
                total++; if (out_data !== se[rcv]) begin bad++; $display("FAIL stream_data%0d got %h want %h", rcv, out_data, se[rcv]); end
                $display("stream: tag %h -> %h", out_tag, out_data);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_a = sa[sent]; in_tag = 4'(sent);
            end
            out_ready = !(cyc >= 4 && cyc < 9);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (rcv != 8) begin bad++; $display("FAIL stream_count got %0d want 8", rcv); end
        total++; if (stalls != 5) begin bad++; $display("FAIL stream_stall_cycles got %0d want 5", stalls); end
        extra = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL stream_extra got %0d want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(posedge clk); #1;
        out_ready = 1'b1; in_b = 32'h3F800000; in_op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h40000000; in_tag = 4'(i + 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        total++; if (out_data !== 32'h0 || out_tag !== 4'h0) begin bad++; $display("FAIL midrst_data_tag got %h/%h want 0/0", out_data, out_tag); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_after got %0d want 0", seen); end
        $display("midflight reset: %0d results after release", seen);
    endtask

    task automatic test_half();
        logic [15:0] ha[2];
        logic [15:0] hb[2];
        logic [15:0] hr[2];
        logic [3:0]  hf[2];
        int lat;
        ha = '{16'h3C00, 16'h7BFF};
        hb = '{16'h3C00, 16'h7BFF};
        hr = '{16'h4000, 16'h7C00};
        hf = '{4'h0, 4'h5};
        h_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            h_in_a = ha[i]; h_in_b = hb[i]; h_in_op = 1'b0; h_in_tag = 4'(i); h_in_valid = 1'b1;
            @(posedge clk); #1;
            h_in_valid = 1'b0;
            lat = 1;
            while (!h_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            total++; if (lat != 3) begin bad++; $display("FAIL half%0d_latency got %0d want 3", i, lat); end
            total++; if (h_out_data !== hr[i]) begin bad++; $display("FAIL half%0d_data got %h want %h", i, h_out_data, hr[i]); end
            total++; if (h_out_flags !== hf[i]) begin bad++; $display("FAIL half%0d_flags got %h want %h", i, h_out_flags, hf[i]); end
            $display("half%0d: %h + %h -> %h flags %h", i, ha[i], hb[i], h_out_data, h_out_flags);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_back_to_back();
        test_reset_midflight();
        test_half();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
